// File: rtl/if_id_pipeline.sv
// IF/ID pipeline register for the 32-bit MIPS-style core: captures the fetched word and PC+4,
// decodes instruction fields, and owns load-use / flush / shared-memory fetch hazard control.
module if_id_pipeline #(
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
   parameter int          STALL_CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [31:0]            instrucao_in,
   input  logic [31:0]            pc_mais4_in,
   input  logic                   flush,
   input  logic                   idex_memRead,
   input  logic [4:0]             idex_rt,
   input  logic                   mem_ocupada,
   output logic [31:0]            instrucao_out,
   output logic [31:0]            pc_mais4_out,
   output logic                   valido,
   output logic [5:0]             opcode,
   output logic [4:0]             rs,
   output logic [4:0]             rt,
   output logic [4:0]             rd,
   output logic [4:0]             shamt,
   output logic [5:0]             funct,
   output logic [31:0]            imediato_ext,
   output logic                   pc_escreve,
   output logic                   bolha_idex,
   output logic [STALL_CNT_W-1:0] contador_stalls
);

   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]            instr_q, instr_d;
   logic [31:0]            pc4_q, pc4_d;
   logic                   valid_q, valid_d;
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
   logic                   hazard_lu;

   assign opcode       = instr_q[31:26];
   assign rs           = instr_q[25:21];
   assign rt           = instr_q[20:16];
   assign rd           = instr_q[15:11];
   assign shamt        = instr_q[10:6];
   assign funct        = instr_q[5:0];
   assign imediato_ext = {{16{instr_q[15]}}, instr_q[15:0]};

   // Only a real instruction can depend on the load; $0 is never a true dependency.
   assign hazard_lu  = valid_q & idex_memRead & (idex_rt != 5'd0) &
                       ((idex_rt == rs) | (idex_rt == rt));
   assign pc_escreve = flush | (~hazard_lu & ~mem_ocupada);
   assign bolha_idex = hazard_lu & ~flush;

   always_comb begin
      // NOTE: every next-state value gets a hold default first, so no path leaves it unassigned (no latch).
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (flush) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         pc4_d   = pc_mais4_in;
      end else if (hazard_lu) begin
         // Dependent instruction stays in ID; ID/EX takes the bubble instead.
      end else if (mem_ocupada) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else begin
         instr_d = instrucao_in;
         pc4_d   = pc_mais4_in;
         valid_d = 1'b1;
      end
      if (!pc_escreve && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign instrucao_out   = instr_q;
   assign pc_mais4_out    = pc4_q;
   assign valido          = valid_q;
   assign contador_stalls = cnt_q;

endmodule

// File: tb/tb_if_id_pipeline.sv
// Directed bench for if_id_pipeline: reset, decode, load-use stall, memory-busy stall,
// flush priority, sign extension and counter saturation (second instance with a 2-bit counter).
module tb_if_id_pipeline;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instrucao_in, pc_mais4_in;
   logic        flush, idex_memRead, mem_ocupada;
   logic [4:0]  idex_rt;

   logic [31:0] instrucao_out, pc_mais4_out, imediato_ext;
   logic        valido, pc_escreve, bolha_idex;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] contador_stalls;

   logic [31:0] s_instr, s_pc4, s_imm;
   logic        s_valido, s_pcw, s_bolha;
   logic [5:0]  s_opcode, s_funct;
   logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
   logic [1:0]  s_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   always #5 clock = ~clock;

   if_id_pipeline #(.NOP_INSTR(32'h0), .STALL_CNT_W(16)) dut (
      .clock(clock), .reset(reset), .instrucao_in(instrucao_in), .pc_mais4_in(pc_mais4_in),
      .flush(flush), .idex_memRead(idex_memRead), .idex_rt(idex_rt), .mem_ocupada(mem_ocupada),
      .instrucao_out(instrucao_out), .pc_mais4_out(pc_mais4_out), .valido(valido),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imediato_ext(imediato_ext), .pc_escreve(pc_escreve), .bolha_idex(bolha_idex),
      .contador_stalls(contador_stalls)
   );

   if_id_pipeline #(.NOP_INSTR(32'h0), .STALL_CNT_W(2)) dut_small (
      .clock(clock), .reset(reset), .instrucao_in(instrucao_in), .pc_mais4_in(pc_mais4_in),
      .flush(flush), .idex_memRead(idex_memRead), .idex_rt(idex_rt), .mem_ocupada(mem_ocupada),
      .instrucao_out(s_instr), .pc_mais4_out(s_pc4), .valido(s_valido),
      .opcode(s_opcode), .rs(s_rs), .rt(s_rt), .rd(s_rd), .shamt(s_shamt), .funct(s_funct),
      .imediato_ext(s_imm), .pc_escreve(s_pcw), .bolha_idex(s_bolha),
      .contador_stalls(s_cnt)
   );

   task automatic edge_step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc4, input logic fl,
                        input logic mrd, input logic [4:0] irt, input logic busy);
      @(negedge clock);
      instrucao_in = instr;
      pc_mais4_in  = pc4;
      flush        = fl;
      idex_memRead = mrd;
      idex_rt      = irt;
      mem_ocupada  = busy;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      instrucao_in = 32'h0; pc_mais4_in = 32'h0; flush = 1'b0;
      idex_memRead = 1'b0; idex_rt = 5'd0; mem_ocupada = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
      edge_step();
      drive(32'h8C220004, 32'h00000004, 1'b0, 1'b0, 5'd0, 1'b0);
      edge_step();
      checks++;
      if (instrucao_out !== 32'h8C220004 || contador_stalls !== 16'd1) begin
         errors++;
         $display("FAIL reset_preload: instr=%h cnt=%0d want 8c220004 cnt=1", instrucao_out, contador_stalls);
      end
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (instrucao_out !== 32'h0 || pc_mais4_out !== 32'h0 || valido !== 1'b0 || contador_stalls !== 16'd0) begin
         errors++;
         $display("FAIL reset_async: instr=%h pc4=%h valido=%b cnt=%0d want 0/0/0/0",
                  instrucao_out, pc_mais4_out, valido, contador_stalls);
      end
      checks++;
      if (pc_escreve !== 1'b1 || bolha_idex !== 1'b0) begin
         errors++;
         $display("FAIL reset_comb: pc_escreve=%b bolha=%b want 1/0", pc_escreve, bolha_idex);
      end
      @(negedge clock);
      reset = 1'b0;
      drive(32'h00221820, 32'h00000008, 1'b0, 1'b0, 5'd0, 1'b0);
      edge_step();
      checks++;
      if (rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd3 || funct !== 6'd32 || opcode !== 6'd0 ||
          shamt !== 5'd0 || valido !== 1'b1 || pc_mais4_out !== 32'h8) begin
         errors++;
         $display("FAIL decode_add: rs=%0d rt=%0d rd=%0d funct=%0d op=%0d sh=%0d v=%b pc4=%h want 1/2/3/32/0/0/1/8",
                  rs, rt, rd, funct, opcode, shamt, valido, pc_mais4_out);
      end
      exp_cnt = 0;
   endtask

   task automatic test_load_use();
      drive(32'h00411020, 32'h0000000C, 1'b0, 1'b1, 5'd1, 1'b0);
      checks++;
      if (pc_escreve !== 1'b0 || bolha_idex !== 1'b1) begin
         errors++;
         $display("FAIL lu_comb: pc_escreve=%b bolha=%b want 0/1", pc_escreve, bolha_idex);
      end
      edge_step();
      exp_cnt++;
      checks++;
      if (instrucao_out !== 32'h00221820 || pc_mais4_out !== 32'h8 || valido !== 1'b1 ||
          contador_stalls !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL lu_hold: instr=%h pc4=%h v=%b cnt=%0d want 00221820/8/1/%0d",
                  instrucao_out, pc_mais4_out, valido, contador_stalls, exp_cnt);
      end
      drive(32'h00411020, 32'h0000000C, 1'b0, 1'b0, 5'd1, 1'b0);
      checks++;
      if (pc_escreve !== 1'b1 || bolha_idex !== 1'b0) begin
         errors++;
         $display("FAIL lu_release: pc_escreve=%b bolha=%b want 1/0", pc_escreve, bolha_idex);
      end
      edge_step();
      checks++;
      if (instrucao_out !== 32'h00411020 || pc_mais4_out !== 32'hC || valido !== 1'b1 ||
          contador_stalls !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL lu_advance: instr=%h pc4=%h v=%b cnt=%0d want 00411020/c/1/%0d",
                  instrucao_out, pc_mais4_out, valido, contador_stalls, exp_cnt);
      end
      // rt field of add $2,$2,$1 is 1: a load into $1 must stall through the rt comparison too
      drive(32'h00001820, 32'h00000010, 1'b0, 1'b1, 5'd1, 1'b0);
      checks++;
      if (pc_escreve !== 1'b0 || bolha_idex !== 1'b1) begin
         errors++;
         $display("FAIL lu_rt_match: pc_escreve=%b bolha=%b want 0/1", pc_escreve, bolha_idex);
      end
      edge_step();
      exp_cnt++;
   endtask

   task automatic test_rt_zero();
      drive(32'h00001820, 32'h00000010, 1'b0, 1'b0, 5'd0, 1'b0);
      edge_step();
      drive(32'h00221820, 32'h00000014, 1'b0, 1'b1, 5'd0, 1'b0);
      checks++;
      if (pc_escreve !== 1'b1 || bolha_idex !== 1'b0) begin
         errors++;
         $display("FAIL rt0_comb: pc_escreve=%b bolha=%b want 1/0", pc_escreve, bolha_idex);
      end
      edge_step();
      checks++;
      if (instrucao_out !== 32'h00221820 || pc_mais4_out !== 32'h14 || contador_stalls !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL rt0_advance: instr=%h pc4=%h cnt=%0d want 00221820/14/%0d",
                  instrucao_out, pc_mais4_out, contador_stalls, exp_cnt);
      end
   endtask

   task automatic test_mem_busy();
      for (int i = 0; i < 2; i++) begin
         drive(32'h12345678, 32'h00000018, 1'b0, 1'b0, 5'd0, 1'b1);
         checks++;
         if (pc_escreve !== 1'b0 || bolha_idex !== 1'b0) begin
            errors++;
            $display("FAIL busy_comb%0d: pc_escreve=%b bolha=%b want 0/0", i, pc_escreve, bolha_idex);
         end
         edge_step();
         exp_cnt++;
         checks++;
         if (instrucao_out !== 32'h0 || valido !== 1'b0 || pc_mais4_out !== 32'h14 ||
             contador_stalls !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL busy_edge%0d: instr=%h v=%b pc4=%h cnt=%0d want 0/0/14/%0d",
                     i, instrucao_out, valido, pc_mais4_out, contador_stalls, exp_cnt);
         end
      end
      drive(32'h12345678, 32'h00000018, 1'b0, 1'b0, 5'd0, 1'b0);
      edge_step();
      checks++;
      if (instrucao_out !== 32'h12345678 || valido !== 1'b1 || pc_mais4_out !== 32'h18) begin
         errors++;
         $display("FAIL busy_release: instr=%h v=%b pc4=%h want 12345678/1/18",
                  instrucao_out, valido, pc_mais4_out);
      end
   endtask

   task automatic test_flush();
      // 0x12345678 has rs=17, rt=20; load-use and busy together must hold, not insert a NOP
      drive(32'hDEADBEEF, 32'h0000001C, 1'b0, 1'b1, 5'd17, 1'b1);
      checks++;
      if (pc_escreve !== 1'b0 || bolha_idex !== 1'b1) begin
         errors++;
         $display("FAIL lu_busy_comb: pc_escreve=%b bolha=%b want 0/1", pc_escreve, bolha_idex);
      end
      edge_step();
      exp_cnt++;
      checks++;
      if (instrucao_out !== 32'h12345678 || valido !== 1'b1 || pc_mais4_out !== 32'h18 ||
          contador_stalls !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL lu_busy_hold: instr=%h v=%b pc4=%h cnt=%0d want 12345678/1/18/%0d",
                  instrucao_out, valido, pc_mais4_out, contador_stalls, exp_cnt);
      end
      drive(32'hDEADBEEF, 32'h00000040, 1'b1, 1'b1, 5'd17, 1'b1);
      checks++;
      if (pc_escreve !== 1'b1 || bolha_idex !== 1'b0) begin
         errors++;
         $display("FAIL flush_comb: pc_escreve=%b bolha=%b want 1/0", pc_escreve, bolha_idex);
      end
      edge_step();
      checks++;
      if (instrucao_out !== 32'h0 || valido !== 1'b0 || pc_mais4_out !== 32'h40 ||
          contador_stalls !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL flush_edge: instr=%h v=%b pc4=%h cnt=%0d want 0/0/40/%0d",
                  instrucao_out, valido, pc_mais4_out, contador_stalls, exp_cnt);
      end
   endtask

   task automatic test_imm();
      drive(32'h2021FFFC, 32'h00000044, 1'b0, 1'b0, 5'd0, 1'b0);
      edge_step();
      checks++;
      if (imediato_ext !== 32'hFFFFFFFC || opcode !== 6'd8) begin
         errors++;
         $display("FAIL imm_neg: imm=%h op=%0d want fffffffc/8", imediato_ext, opcode);
      end
      drive(32'h20217FFF, 32'h00000048, 1'b0, 1'b0, 5'd0, 1'b0);
      edge_step();
      checks++;
      if (imediato_ext !== 32'h00007FFF) begin
         errors++;
         $display("FAIL imm_pos: imm=%h want 00007fff", imediato_ext);
      end
      drive(32'h00000000, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd0, 1'b0);
      edge_step();
      checks++;
      if (pc_mais4_out !== 32'hFFFFFFFC) begin
         errors++;
         $display("FAIL pc_pass: pc4=%h want fffffffc", pc_mais4_out);
      end
   endtask

   task automatic test_saturation();
      @(negedge clock);
      reset = 1'b1;
      #1;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         drive(32'h12345678, 32'h00000050, 1'b0, 1'b0, 5'd0, 1'b1);
         edge_step();
         checks++;
         if (s_cnt !== 2'((i > 3) ? 3 : i) || contador_stalls !== 16'(i)) begin
            errors++;
            $display("FAIL sat_cycle%0d: small=%0d wide=%0d want %0d/%0d",
                     i, s_cnt, contador_stalls, (i > 3) ? 3 : i, i);
         end
      end
      drive(32'h12345678, 32'h00000050, 1'b0, 1'b0, 5'd0, 1'b0);
      edge_step();
      checks++;
      if (s_cnt !== 2'd3 || s_valido !== 1'b1) begin
         errors++;
         $display("FAIL sat_hold: small=%0d v=%b want 3/1", s_cnt, s_valido);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_rt_zero();
      test_mem_busy();
      test_flush();
      test_imm();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_id_pipeline.md
Name: if_id_pipeline

Overview:
Pipeline register between the instruction-fetch stage and the decode stage of the 32-bit MIPS-style core. Captures the fetched instruction and PC+4 each cycle and decodes the instruction fields for ID. Owns the fetch-side hazard control: load-use stall, branch/jump flush, and the structural stall caused by MEM using the shared instruction/data memory. Drives the fetch stage's PC write enable and a bubble request to ID/EX.

Parameters:
NOP_INSTR, 32'h00000000, instruction word loaded into the register on a bubble or flush (sll $0,$0,0)
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-high
instrucao_in  input  32  fetched word from the shared memory output
pc_mais4_in  input  32  PC+4 from the fetch-stage adder
flush  input  1  branch taken / jump resolved; discard the instruction being fetched
idex_memRead  input  1  instruction in ID/EX is a load
idex_rt  input  5  destination register of the load in ID/EX
mem_ocupada  input  1  MEM stage owns the shared memory this cycle; no fetch occurs
instrucao_out  output  32  registered instruction
pc_mais4_out  output  32  registered PC+4
valido  output  1  instrucao_out is a real instruction
opcode  output  6  instrucao_out[31:26]
rs  output  5  instrucao_out[25:21]
rt  output  5  instrucao_out[20:16]
rd  output  5  instrucao_out[15:11]
shamt  output  5  instrucao_out[10:6]
funct  output  6  instrucao_out[5:0]
imediato_ext  output  32  instrucao_out[15:0] sign-extended
pc_escreve  output  1  PC write enable to the fetch stage
bolha_idex  output  1  force ID/EX control signals to zero this cycle
contador_stalls  output  STALL_CNT_W  saturating count of cycles with pc_escreve=0

Behaviour:
- Reset (asynchronous, any time, including mid-stall): instrucao_out=NOP_INSTR, pc_mais4_out=0, valido=0, contador_stalls=0. Combinational outputs follow from the reset register state: pc_escreve=1 unless mem_ocupada, and bolha_idex=0.
- Load-use hazard, combinational: hazard_lu = valido & idex_memRead & (idex_rt != 0) & (idex_rt == rs | idex_rt == rt).
- pc_escreve = flush | (~hazard_lu & ~mem_ocupada).
- bolha_idex = hazard_lu & ~flush.
- On the rising edge, evaluate in priority order:
  1. flush: instrucao_out<=NOP_INSTR, valido<=0, pc_mais4_out<=pc_mais4_in. Overrides both stalls.
  2. hazard_lu: hold all registers. The dependent instruction stays in ID, and ID/EX receives a bubble.
  3. mem_ocupada: instrucao_out<=NOP_INSTR, valido<=0, pc_mais4_out held. The fetch slot is lost and the PC is held, so the same address is refetched next cycle.
  4. Otherwise: instrucao_out<=instrucao_in, pc_mais4_out<=pc_mais4_in, valido<=1.
- Latency: one cycle from instrucao_in to instrucao_out. Decode fields and imediato_ext are purely combinational from instrucao_out, with no additional latency.
- A load-use hazard lasts exactly one cycle per load. On the next cycle the load has moved to EX/MEM and idex_memRead reflects the bubble (0).
- hazard_lu and mem_ocupada together: hold (rule 2). No NOP is inserted over a valid held instruction.
- idex_rt==0 never stalls.
- contador_stalls increments on each edge where pc_escreve==0 and saturates at all-ones; there is no wrap-around.
- pc_mais4_in + anything: no arithmetic is performed here. Values pass through unchanged, so wrap at 32'hFFFFFFFC+4 is the adder's concern.

Test Plan:
- Reset asserted mid-run with instrucao_out=32'h8C220004: outputs go to 0/NOP/valido=0 immediately, without waiting for a clock edge. Release reset and apply instrucao_in=32'h00221820, pc_mais4_in=32'h00000008: next edge gives rs=1, rt=2, rd=3, funct=32, valido=1.
- IF/ID holds add $3,$1,$2 (rs=1); idex_memRead=1, idex_rt=1: pc_escreve=0, bolha_idex=1, registers held for one edge, contador_stalls=1. Then idex_memRead=0: normal advance.
- Same as above but idex_rt=0: no stall, pc_escreve=1, bolha_idex=0.
- mem_ocupada=1 for 2 cycles with instrucao_in=32'h12345678: pc_escreve=0, valido=0, instrucao_out=NOP, pc_mais4_out unchanged, contador_stalls +2. Deassert: the word loads with valido=1.
- flush=1 together with a load-use hazard and mem_ocupada=1: pc_escreve=1, bolha_idex=0, next edge gives valido=0, instrucao_out=NOP, pc_mais4_out=pc_mais4_in.
- imediato_ext: instrucao_in=32'h2021FFFC gives 32'hFFFFFFFC. instrucao_in=32'h20217FFF gives 32'h00007FFF.
- STALL_CNT_W=2, hold mem_ocupada=1 for 5 cycles: contador_stalls reaches 3 and stays at 3.
